// File: rtl/pwm_pkg.sv
// Shared types and widths for the PWM ramp sequencer: FSM state encoding and the
// saturating duty-step helper used by the duty datapath.
package pwm_pkg;

    localparam int DUTY_W   = 8;
    localparam int PERIOD_W = 11;

    typedef enum logic [2:0] {
        IDLE,
        RAMP,
        HOLD,
        REV_DOWN,
        DEAD
    } state_t;

    // Moves cur one step toward goal; the 9-bit distance lets the last step land exactly on goal.
    function automatic logic [DUTY_W-1:0] step_duty(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] goal,
        input logic [DUTY_W:0]   step
    );
        logic [DUTY_W:0] diff;
        if (goal >= cur) begin
            diff      = {1'b0, goal} - {1'b0, cur};
            step_duty = (diff > step) ? cur + step[DUTY_W-1:0] : goal;
        end else begin
            diff      = {1'b0, cur} - {1'b0, goal};
            step_duty = (diff > step) ? cur - step[DUTY_W-1:0] : goal;
        end
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Free-running PWM period counter plus a divider over periods; step_tick pulses for one
// cycle on the clock where both wrap.
module pwm_tick_gen
    import pwm_pkg::*;
#(
    parameter int PWM_PERIOD = 1025,
    parameter int RAMP_DIV   = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic step_tick
);

    localparam int                   DIV_W       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(PWM_PERIOD - 1);
    localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(RAMP_DIV - 1);

    logic [PERIOD_W-1:0] r_period;
    logic [DIV_W-1:0]    r_div;
    logic                w_period_wrap;
    logic                w_div_wrap;

    assign w_period_wrap = (r_period == PERIOD_LAST);
    assign w_div_wrap    = (r_div == DIV_LAST);
    assign step_tick     = w_period_wrap && w_div_wrap;

    // NOTE: sequential state uses <= so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= '0;
            r_div    <= '0;
        end else if (w_period_wrap) begin
            r_period <= '0;
            r_div    <= w_div_wrap ? '0 : r_div + DIV_W'(1);
        end else begin
            r_period <= r_period + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramp/reversal sequencer in front of the PWM motor drive: accepts duty/direction commands
// and walks DUTY toward them one STEP per step_tick, with a dead time on direction flips.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int PWM_PERIOD  = 1025,
    parameter int RAMP_DIV    = 16,
    parameter int STEP        = 4,
    parameter int DEAD_CYCLES = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              estop,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_duty,
    input  logic              cmd_dir,
    output logic [DUTY_W-1:0] duty,
    output logic              dir,
    output logic              en,
    output logic              busy,
    output logic              at_target
);

    localparam int                 DEAD_W    = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [DUTY_W:0]   STEP_V    = (DUTY_W + 1)'(STEP);

    state_t              r_state, w_next;
    logic [DUTY_W-1:0]   r_duty, w_duty_nxt;
    logic [DUTY_W-1:0]   r_tgt, w_tgt, w_tgt_nxt, w_goal;
    logic                r_dir, w_dir_nxt;
    logic                r_tdir, w_tdir, w_tdir_nxt;
    logic [DEAD_W-1:0]   r_dead, w_dead_nxt;
    logic                r_live;
    logic                w_tick, w_acc, w_reverse;

    pwm_tick_gen #(
        .PWM_PERIOD (PWM_PERIOD),
        .RAMP_DIV   (RAMP_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_tick (w_tick)
    );

    // A command arriving on a step_tick edge steers that very step.
    assign cmd_ready = r_live && !estop && (r_state inside {IDLE, RAMP, HOLD});
    assign w_acc     = cmd_valid && cmd_ready;
    assign w_tgt     = w_acc ? cmd_duty : r_tgt;
    assign w_tdir    = w_acc ? cmd_dir  : r_tdir;
    assign w_reverse = (w_tdir != r_dir);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next     = r_state;
        w_duty_nxt = r_duty;
        w_dir_nxt  = r_dir;
        w_tgt_nxt  = w_tgt;
        w_tdir_nxt = w_tdir;
        w_dead_nxt = r_dead;
        w_goal     = w_reverse ? '0 : w_tgt;

        if (estop) begin
            w_next     = IDLE;
            w_duty_nxt = '0;
            w_tgt_nxt  = '0;
            w_tdir_nxt = r_dir;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        if (cmd_dir != r_dir) begin
                            w_next     = DEAD;
                            w_dead_nxt = '0;
                        end else if (cmd_duty != '0) begin
                            w_next = RAMP;
                        end
                    end
                end
                RAMP, HOLD, REV_DOWN: begin
                    if (w_tick) w_duty_nxt = step_duty(r_duty, w_goal, STEP_V);
                    if (w_reverse) begin
                        w_next = (w_duty_nxt == '0) ? DEAD : REV_DOWN;
                        w_dead_nxt = '0;
                    end else if (w_duty_nxt == w_tgt) begin
                        w_next = (w_tgt != '0) ? HOLD : IDLE;
                    end else begin
                        w_next = RAMP;
                    end
                end
                DEAD: begin
                    if (r_dead == DEAD_LAST) begin
                        w_dir_nxt = r_tdir;
                        w_next    = (r_tgt != '0) ? RAMP : IDLE;
                    end else begin
                        w_dead_nxt = r_dead + DEAD_W'(1);
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_duty  <= '0;
            r_dir   <= 1'b0;
            r_tgt   <= '0;
            r_tdir  <= 1'b0;
            r_dead  <= '0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_duty  <= w_duty_nxt;
            r_dir   <= w_dir_nxt;
            r_tgt   <= w_tgt_nxt;
            r_tdir  <= w_tdir_nxt;
            r_dead  <= w_dead_nxt;
            r_live  <= 1'b1;
        end
    end

    // EN follows a nonzero DUTY in the driving states, so it rises with the first step and
    // falls on the same edge DUTY reaches 0.
    assign duty      = r_duty;
    assign dir       = r_dir;
    assign en        = (r_duty != '0) && (r_state inside {RAMP, HOLD, REV_DOWN});
    assign busy      = (r_state inside {RAMP, REV_DOWN, DEAD});
    assign at_target = (r_state == HOLD);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed scenarios with literal expectations plus randomized
// commands/ESTOP, all compared every cycle against a behavioural model of the sequencer.
module tb_pwm_ramp_ctrl;

    localparam int P        = 8;
    localparam int D        = 2;
    localparam int STEP     = 16;
    localparam int DEAD     = 5;
    localparam int TICK_LEN = P * D;

    // Model modes: idle, ramping, holding, reversing down, dead time.
    localparam int MI = 0, MR = 1, MH = 2, MV = 3, MD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       estop = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_duty = 8'd0;
    logic       cmd_dir = 1'b0;
    logic       cmd_ready;
    logic [7:0] duty;
    logic       dir, en, busy, at_target;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    typedef struct {
        int mode;
        int duty;
        int dir;
        int tgt;
        int tdir;
        int dead;
        int cyc;
        int live;
    } model_t;

    model_t m;

    pwm_ramp_ctrl #(
        .PWM_PERIOD  (P),
        .RAMP_DIV    (D),
        .STEP        (STEP),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .estop     (estop),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_duty  (cmd_duty),
        .cmd_dir   (cmd_dir),
        .duty      (duty),
        .dir       (dir),
        .en        (en),
        .busy      (busy),
        .at_target (at_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic int toward(input int cur, input int goal);
        if (goal > cur) return (cur + STEP < goal) ? cur + STEP : goal;
        return (cur - STEP > goal) ? cur - STEP : goal;
    endfunction

    function automatic model_t reset_model();
        model_t r;
        r = '{default: 0};
        return r;
    endfunction

    function automatic model_t model_next(input model_t c, input bit stop, input bit vld,
                                          input int cduty, input int cdir);
        model_t n;
        bit     tick, rdy, acc;
        n    = c;
        tick = (c.cyc % TICK_LEN) == TICK_LEN - 1;
        rdy  = c.live != 0 && !stop && (c.mode == MI || c.mode == MR || c.mode == MH);
        acc  = vld && rdy;
        n.cyc  = c.cyc + 1;
        n.live = 1;
        if (stop) begin
            n.mode = MI;
            n.duty = 0;
            n.tgt  = 0;
            n.tdir = c.dir;
            return n;
        end
        if (acc) begin
            n.tgt  = cduty;
            n.tdir = cdir;
        end
        case (c.mode)
            MI: if (acc) begin
                if (cdir != c.dir) begin
                    n.mode = MD;
                    n.dead = DEAD;
                end else if (cduty > 0) begin
                    n.mode = MR;
                end
            end
            MR, MH, MV: begin
                if (n.tdir != c.dir) begin
                    if (tick) n.duty = toward(c.duty, 0);
                    n.mode = (n.duty == 0) ? MD : MV;
                    n.dead = DEAD;
                end else begin
                    if (tick) n.duty = toward(c.duty, n.tgt);
                    if (n.duty == n.tgt) n.mode = (n.tgt > 0) ? MH : MI;
                    else n.mode = MR;
                end
            end
            MD: begin
                n.dead = c.dead - 1;
                if (n.dead == 0) begin
                    n.dir  = c.tdir;
                    n.mode = (c.tgt > 0) ? MR : MI;
                end
            end
            default: n.mode = MI;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= reset_model();
        else        m <= model_next(m, estop, cmd_valid, int'(cmd_duty), int'(cmd_dir));
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("duty", duty, m.duty);
            check("dir", dir, m.dir);
            check("en", en, 32'(m.duty > 0 && (m.mode == MR || m.mode == MH || m.mode == MV)));
            check("busy", busy, 32'(m.mode == MR || m.mode == MV || m.mode == MD));
            check("at_target", at_target, 32'(m.mode == MH));
            check("cmd_ready", cmd_ready,
                  32'(m.live != 0 && !estop && (m.mode == MI || m.mode == MR || m.mode == MH)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int d, input int dr);
        bit done;
        done      = 1'b0;
        cmd_duty  = 8'(d);
        cmd_dir   = dr[0];
        cmd_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            if (cmd_ready) done = 1'b1;
            cyc();
        end
        cmd_valid = 1'b0;
        check("cmd_accepted", 32'(done), 1);
    endtask

    task automatic expect_step(input string name, input int exp_duty, input int exp_gap);
        logic [7:0] old;
        int         dt;
        old = duty;
        dt  = 0;
        while (duty == old && dt < 100) begin
            cyc();
            dt++;
        end
        check({name, "_duty"}, duty, exp_duty);
        check({name, "_en"}, en, 32'(exp_duty > 0));
        if (exp_gap > 0) check({name, "_gap"}, dt, exp_gap);
    endtask

    task automatic pick_cmd();
        case ($urandom_range(0, 3))
            0:       cmd_duty = 8'd0;
            1:       cmd_duty = 8'd255;
            2:       cmd_duty = 8'(16 * $urandom_range(0, 15));
            default: cmd_duty = 8'($urandom_range(0, 255));
        endcase
        cmd_dir = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int dt;
        int estop_hold;
        bit acc_prev;

        // Reset state and release
        cyc(3);
        check("rst_duty", duty, 0);
        check("rst_en", en, 0);
        check("rst_ready", cmd_ready, 0);
        rst_n = 1'b1;
        #1;
        cmp_en = 1'b1;
        check("ready_at_release", cmd_ready, 0);
        cyc();
        check("ready_after_release", cmd_ready, 1);

        // Ramp up to 40
        send(40, 0);
        check("ramp_busy", busy, 1);
        check("en_before_step", en, 0);
        expect_step("up1", 16, -1);
        expect_step("up2", 32, 16);
        expect_step("up3", 40, 16);
        check("hold40_at_target", at_target, 1);
        check("hold40_busy", busy, 0);

        // Ramp down to stop
        send(0, 0);
        expect_step("dn1", 24, -1);
        expect_step("dn2", 8, 16);
        expect_step("dn3", 0, 16);
        check("stop_busy", busy, 0);
        check("stop_at_target", at_target, 0);
        check("stop_ready", cmd_ready, 1);

        // Reversal from HOLD at 32
        send(32, 0);
        expect_step("r_up1", 16, -1);
        expect_step("r_up2", 32, 16);
        send(16, 1);
        check("rev_ready", cmd_ready, 0);
        check("rev_busy", busy, 1);
        expect_step("rv1", 16, -1);
        expect_step("rv2", 0, 16);
        check("dead_dir_old", dir, 0);
        check("dead_busy", busy, 1);
        check("dead_ready", cmd_ready, 0);
        dt = 0;
        while (dir == 1'b0 && dt < 50) begin
            check("dead_en", en, 0);
            cyc();
            dt++;
        end
        check("dead_len", dt, 5);
        check("after_dead_ready", cmd_ready, 1);
        expect_step("rv3", 16, -1);
        check("rev_hold", at_target, 1);
        check("rev_dir", dir, 1);

        // ESTOP at 48
        send(48, 1);
        expect_step("e_up1", 32, -1);
        expect_step("e_up2", 48, 16);
        estop     = 1'b1;
        cmd_valid = 1'b1;
        cmd_duty  = 8'd100;
        cmd_dir   = 1'b1;
        #1;
        check("estop_ready_now", cmd_ready, 0);
        cyc();
        check("estop_duty", duty, 0);
        check("estop_en", en, 0);
        check("estop_at_target", at_target, 0);
        check("estop_dir_kept", dir, 1);
        cyc(3);
        check("estop_ready_held", cmd_ready, 0);
        check("estop_busy", busy, 0);
        cmd_valid = 1'b0;
        estop     = 1'b0;
        #1;
        check("estop_release_ready", cmd_ready, 1);
        cyc();

        // Retarget mid-ramp
        send(200, 1);
        expect_step("rt1", 16, -1);
        expect_step("rt2", 32, 16);
        expect_step("rt3", 48, 16);
        expect_step("rt4", 64, 16);
        send(32, 1);
        expect_step("rt5", 48, -1);
        expect_step("rt6", 32, 16);
        check("rt_hold", at_target, 1);
        cyc(40);
        check("rt_no_overshoot", duty, 32);

        // Reset mid-ramp
        send(200, 1);
        cyc(20);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_duty", duty, 0);
        check("mr_dir", dir, 0);
        check("mr_en", en, 0);
        check("mr_busy", busy, 0);
        check("mr_at_target", at_target, 0);
        check("mr_ready", cmd_ready, 0);
        cyc(2);
        rst_n = 1'b1;
        #1;
        check("mr_ready_release", cmd_ready, 0);
        cyc();
        check("mr_ready_after", cmd_ready, 1);

        // Saturation near full scale
        send(250, 0);
        dt = 0;
        while (!at_target && dt < 400) begin
            cyc();
            dt++;
        end
        check("sat250", duty, 250);
        send(255, 0);
        dt = 0;
        while (!(at_target && duty == 8'd255) && dt < 100) begin
            cyc();
            dt++;
        end
        check("sat255", duty, 255);

        // Randomized commands and ESTOP pulses
        estop_hold = 0;
        acc_prev   = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (cmd_valid && (acc_prev || $urandom_range(0, 7) == 0)) begin
                cmd_valid = 1'b0;
            end else if (!cmd_valid && $urandom_range(0, 39) == 0) begin
                pick_cmd();
                cmd_valid = 1'b1;
            end
            if (estop_hold > 0) estop_hold--;
            else if ($urandom_range(0, 299) == 0) estop_hold = $urandom_range(1, 4);
            estop = (estop_hold > 0);
            #1;
            acc_prev = cmd_valid && cmd_ready;
            cyc();
        end
        cmd_valid = 1'b0;
        estop     = 1'b0;
        cyc(2);
        cmp_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
